shutter_pwm_bank: RTL

- Parametrised successor to the 4-channel shutter slot-card driver.
- Drives NUM_CH H-bridge shutter channels from one shared PWM period counter.
- Adds shadowed, glitch-free duty and phase updates, a one-period brake on direction reversal, and a per-channel actuation sequencer (high-duty kick pulse, then hold duty).
- Configured by the slot-card SPI command bus; a slot-level wrapper converts drive/oe into tristated card pins.

---
 rtl/shutter_pkg.sv | 24 ++
 rtl/shutter_pwm_channel.sv | 117 +++++++++++
 rtl/shutter_pwm_bank.sv | 116 +++++++++++
 3 files changed

// File: rtl/shutter_pkg.sv
// Shared constants for the shutter PWM bank: SPI command codes, payload layout,
// sequencer state encoding and bank modes.
package shutter_pkg;

  localparam logic [15:0] C_SET_ENABLE_SHUTTER_BANK = 16'h0050;
  localparam logic [15:0] C_SET_SHUTTER_PERIOD      = 16'h0051;
  localparam logic [15:0] C_SET_SHUTTER_DUTY        = 16'h0052;
  localparam logic [15:0] C_SET_SHUTTER_HOLD        = 16'h0053;
  localparam logic [15:0] C_SET_SHUTTER_ACTUATE     = 16'h0054;

  localparam int P_CHAN_LO  = 32;
  localparam int P_KICK_LO  = 24;
  localparam int P_PHASE    = 16;
  localparam int P_VALUE_LO = 0;
  localparam int P_MODE_LO  = 0;

  localparam logic [1:0] SEQ_IDLE = 2'd0;
  localparam logic [1:0] SEQ_KICK = 2'd1;
  localparam logic [1:0] SEQ_HOLD = 2'd2;

  localparam logic [2:0] DISABLED_MODE = 3'd0;
  localparam logic [2:0] ONE_WIRE_MODE = 3'd1;

endpackage

// File: rtl/shutter_pwm_channel.sv
// One H-bridge shutter channel: shadow/active duty and phase, reversal brake,
// kick/hold actuation sequencer and registered bridge drive.
module shutter_pwm_channel
  import shutter_pkg::*;
#(
  parameter int CNTR_WIDTH = 12,
  parameter int KICK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  boundary_i,
  input  logic                  em_stop_i,
  input  logic                  drive_en_i,
  input  logic [CNTR_WIDTH-1:0] cntr_i,
  input  logic                  duty_we_i,
  input  logic                  hold_we_i,
  input  logic                  act_we_i,
  input  logic [CNTR_WIDTH-1:0] value_i,
  input  logic                  phase_i,
  input  logic [KICK_WIDTH-1:0] kick_i,
  output logic                  in_a_o,
  output logic                  in_b_o,
  output logic                  busy_o
);

  logic [CNTR_WIDTH-1:0] sh_duty_q, sh_duty_d, duty_q, duty_d, hold_q, hold_d;
  logic                  sh_phase_q, sh_phase_d, phase_q, phase_d;
  logic [1:0]            state_q, state_d;
  logic [KICK_WIDTH-1:0] kick_q, kick_d;
  logic                  pwm_q, pwm_d, in_a_q, in_a_d, in_b_q, in_b_d;
  logic                  reverse;

  // Only a channel that was actually driving gets a brake period on reversal.
  assign reverse = (sh_phase_q != phase_q) && (duty_q != '0);

  always_comb begin
    sh_duty_d  = sh_duty_q;
    sh_phase_d = sh_phase_q;
    duty_d     = duty_q;
    phase_d    = phase_q;
    hold_d     = hold_q;
    state_d    = state_q;
    kick_d     = kick_q;
    pwm_d      = pwm_q;

    if (boundary_i) begin
      duty_d  = sh_duty_q;
      phase_d = sh_phase_q;
      pwm_d   = (sh_duty_q != '0) && !reverse;
    end else if (cntr_i == duty_q) begin
      pwm_d = 1'b0;
    end

    if (boundary_i && (state_q == SEQ_KICK)) begin
      if (kick_q <= KICK_WIDTH'(1)) begin
        sh_duty_d = hold_q;
        state_d   = (hold_q != '0) ? SEQ_HOLD : SEQ_IDLE;
      end else begin
        kick_d = kick_q - KICK_WIDTH'(1);
      end
    end

    // Commands override the sequencer; the boundary above already saw the old shadow.
    if (hold_we_i) hold_d = value_i;
    if (duty_we_i) begin
      sh_duty_d  = value_i;
      sh_phase_d = phase_i;
      state_d    = SEQ_IDLE;
    end
    if (act_we_i) begin
      sh_duty_d  = value_i;
      sh_phase_d = phase_i;
      kick_d     = kick_i;
      state_d    = (kick_i != '0) ? SEQ_KICK : SEQ_HOLD;
    end

    if (em_stop_i) begin
      pwm_d     = 1'b0;
      state_d   = SEQ_IDLE;
      sh_duty_d = '0;
    end

    in_a_d = drive_en_i && !em_stop_i && phase_q && pwm_q;
    in_b_d = drive_en_i && !em_stop_i && !phase_q && pwm_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sh_duty_q  <= '0;
      sh_phase_q <= 1'b0;
      duty_q     <= '0;
      phase_q    <= 1'b0;
      hold_q     <= '0;
      state_q    <= SEQ_IDLE;
      kick_q     <= '0;
      pwm_q      <= 1'b0;
      in_a_q     <= 1'b0;
      in_b_q     <= 1'b0;
    end else begin
      sh_duty_q  <= sh_duty_d;
      sh_phase_q <= sh_phase_d;
      duty_q     <= duty_d;
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      kick_q     <= kick_d;
      pwm_q      <= pwm_d;
      in_a_q     <= in_a_d;
      in_b_q     <= in_b_d;
    end
  end

  assign in_a_o = in_a_q;
  assign in_b_o = in_b_q;
  assign busy_o = (state_q != SEQ_IDLE);

endmodule

// File: rtl/shutter_pwm_bank.sv
// Shutter PWM bank: shared period counter, SPI command decode and NUM_CH
// shutter_pwm_channel instances.
module shutter_pwm_bank
  import shutter_pkg::*;
#(
  parameter int DEV_ID      = 0,
  parameter int NUM_CH      = 4,
  parameter int CNTR_WIDTH  = 12,
  parameter int INIT_PERIOD = 1900,
  parameter int KICK_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [15:0]       spi_cmd_r,
  input  logic [7:0]        spi_addr_r,
  input  logic [39:0]       spi_data_r,
  input  logic              spi_data_valid_r,
  input  logic              EM_STOP,
  output logic [NUM_CH-1:0] in_a,
  output logic [NUM_CH-1:0] in_b,
  output logic              out_oe,
  output logic [NUM_CH-1:0] busy
);

  localparam logic [CNTR_WIDTH-1:0] PERIOD_RST = CNTR_WIDTH'(INIT_PERIOD);

  logic [CNTR_WIDTH-1:0] cntr_q, cntr_d, period_q, period_d, pending_q, pending_d;
  logic [2:0]            mode_q, mode_d;
  logic [7:0]            chan;
  logic [CNTR_WIDTH-1:0] value;
  logic [KICK_WIDTH-1:0] kick;
  logic                  phase, accept, boundary, drive_en;
  logic                  cmd_enable, cmd_period, cmd_duty, cmd_hold, cmd_act;
  logic                  unused_payload;

  assign chan  = spi_data_r[P_CHAN_LO +: 8];
  assign value = spi_data_r[P_VALUE_LO +: CNTR_WIDTH];
  assign kick  = spi_data_r[P_KICK_LO +: KICK_WIDTH];
  assign phase = spi_data_r[P_PHASE];
  assign unused_payload = ^spi_data_r;

  // EM_STOP masks every command so it always wins a same-cycle write.
  assign accept = spi_data_valid_r && (spi_addr_r == 8'(DEV_ID)) &&
                  (chan < 8'(NUM_CH)) && !EM_STOP;

  assign cmd_enable = accept && (spi_cmd_r == C_SET_ENABLE_SHUTTER_BANK);
  assign cmd_period = accept && (spi_cmd_r == C_SET_SHUTTER_PERIOD);
  assign cmd_duty   = accept && (spi_cmd_r == C_SET_SHUTTER_DUTY);
  assign cmd_hold   = accept && (spi_cmd_r == C_SET_SHUTTER_HOLD);
  assign cmd_act    = accept && (spi_cmd_r == C_SET_SHUTTER_ACTUATE);

  assign boundary = !EM_STOP && ((cntr_q == '0) || (cntr_q == period_q));
  assign drive_en = (mode_q > ONE_WIRE_MODE);
  assign out_oe   = drive_en;

  always_comb begin
    cntr_d    = cntr_q;
    period_d  = period_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    if (EM_STOP) begin
      cntr_d    = '0;
      pending_d = PERIOD_RST;
    end else begin
      if (boundary) begin
        cntr_d   = CNTR_WIDTH'(1);
        period_d = pending_q;
      end else begin
        cntr_d = cntr_q + CNTR_WIDTH'(1);
      end
      if (cmd_enable) mode_d = spi_data_r[P_MODE_LO +: 3];
      if (cmd_period && (value >= CNTR_WIDTH'(2))) pending_d = value;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cntr_q    <= '0;
      period_q  <= PERIOD_RST;
      pending_q <= PERIOD_RST;
      mode_q    <= DISABLED_MODE;
    end else begin
      cntr_q    <= cntr_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = (chan == 8'(i));

    shutter_pwm_channel #(
      .CNTR_WIDTH(CNTR_WIDTH),
      .KICK_WIDTH(KICK_WIDTH)
    ) u_ch (
      .clk       (clk),
      .resetn    (resetn),
      .boundary_i(boundary),
      .em_stop_i (EM_STOP),
      .drive_en_i(drive_en),
      .cntr_i    (cntr_q),
      .duty_we_i (cmd_duty && sel),
      .hold_we_i (cmd_hold && sel),
      .act_we_i  (cmd_act && sel),
      .value_i   (value),
      .phase_i   (phase),
      .kick_i    (kick),
      .in_a_o    (in_a[i]),
      .in_b_o    (in_b[i]),
      .busy_o    (busy[i])
    );
  end

endmodule
